branch_resolve_unit: RTL and testbench

- Pipelined branch/jump resolution functional unit, issued from the branch reservation station; results go to the CDB arbiter through an internal result FIFO.
- Resolves B-type, JAL and JALR:
  - evaluates the condition;
  - computes target, link (pc+4) and the correct next PC;
  - compares the outcome against the front-end prediction to raise mispredict.
- Parametrised in width, pipeline latency and result-buffer depth; supports global flush.

---
 rtl/branch_resolve_unit.sv | 194 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - pipelined branch/jump resolution unit with credit-managed result FIFO
//
// Resolves BR (funct3 conditions), JAL and JALR ops issued from the branch
// reservation station. It produces the direction, link (pc+4), correct next
// PC, mispredict and misaligned flags. Results are queued in order for the
// CDB arbiter.
//
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   flush                  squash every in-flight and buffered result
//   in_valid/in_ready      issue handshake
//   in_tag, in_kind        ROB tag; 0=BR 1=JAL 2=JALR 3=reserved (BR not-taken)
//   in_func                funct3 for BR
//   in_pc, in_imm          instruction PC, sign-extended immediate
//   in_rs1, in_rs2         operands (rs1 is the JALR base)
//   in_pred_taken/_target  front-end prediction
//   out_valid/out_ready    result FIFO head handshake with the CDB
//   out_tag, out_taken     head tag, resolved direction
//   out_link, out_next_pc  pc+4 and correct next PC
//   out_mispredict         resolution differs from prediction
//   out_misaligned         taken target with bit1 set
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int LATENCY   = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [1:0]       in_kind,
  input  logic [2:0]       in_func,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_link,
  output logic [XLEN-1:0]  out_next_pc,
  output logic             out_mispredict,
  output logic             out_misaligned
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  link;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
  } s1_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  link;
    logic [XLEN-1:0]  next_pc;
    logic             mispredict;
    logic             misaligned;
  } res_t;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_fcnt;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  res_t          r_mem [OUT_DEPTH];

  logic          w_accept;
  logic          w_deq;
  logic          w_eq, w_lt, w_ltu, w_cond, w_taken;
  logic [XLEN-1:0] w_sum;
  s1_t           w_s1;
  s1_t           w_s2;
  logic          w_s2_valid;
  res_t          w_res;

  // Credits are taken from the registered count only, so every accepted op
  // is guaranteed a FIFO slot and the pipe never has to stall.
  assign in_ready  = (r_cnt < CW'(OUT_DEPTH)) & ~flush;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_fcnt != '0);
  assign w_deq     = out_valid & out_ready & ~flush;

  // Stage 1: condition and target
  assign w_eq  = (in_rs1 == in_rs2);
  assign w_lt  = ($signed(in_rs1) < $signed(in_rs2));
  assign w_ltu = (in_rs1 < in_rs2);
  assign w_sum = ((in_kind == 2'd2) ? in_rs1 : in_pc) + in_imm;

  always_comb begin
    w_cond  = 1'b0;
    w_taken = 1'b0;
    case (in_func)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = ~w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = ~w_ltu;
      default: w_cond = 1'b0;
    endcase
    case (in_kind)
      2'd0:       w_taken = w_cond;
      2'd1, 2'd2: w_taken = 1'b1;
      default:    w_taken = 1'b0;
    endcase
  end

  assign w_s1.tag         = in_tag;
  assign w_s1.taken       = w_taken;
  assign w_s1.target      = (in_kind == 2'd2) ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  assign w_s1.link        = in_pc + XLEN'(4);
  assign w_s1.pred_taken  = in_pred_taken;
  assign w_s1.pred_target = in_pred_target;

  generate
    if (LATENCY == 2) begin : g_lat2
      logic r_s1_valid;
      s1_t  r_s1;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_s1_valid <= 1'b0;
          r_s1       <= '0;
        end else begin
          r_s1_valid <= w_accept & ~flush;
          if (w_accept) r_s1 <= w_s1;
        end
      end
      assign w_s2       = r_s1;
      assign w_s2_valid = r_s1_valid & ~flush;
    end else begin : g_lat1
      assign w_s2       = w_s1;
      assign w_s2_valid = w_accept;
    end
  endgenerate

  // Stage 2: prediction compare and alignment
  assign w_res.tag        = w_s2.tag;
  assign w_res.taken      = w_s2.taken;
  assign w_res.link       = w_s2.link;
  assign w_res.next_pc    = w_s2.taken ? w_s2.target : w_s2.link;
  assign w_res.mispredict = (w_s2.taken != w_s2.pred_taken) |
                            (w_s2.taken & (w_s2.target != w_s2.pred_target));
  assign w_res.misaligned = w_s2.taken & w_s2.target[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(w_accept) - CW'(w_deq);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_s2_valid) begin
        r_mem[r_tail] <= w_res;
        r_tail        <= r_tail + PW'(1);
      end
      if (w_deq) r_head <= r_head + PW'(1);
      r_fcnt <= r_fcnt + CW'(w_s2_valid) - CW'(w_deq);
    end
  end

  assign out_tag        = r_mem[r_head].tag;
  assign out_taken      = r_mem[r_head].taken;
  assign out_link       = r_mem[r_head].link;
  assign out_next_pc    = r_mem[r_head].next_pc;
  assign out_mispredict = r_mem[r_head].mispredict;
  assign out_misaligned = r_mem[r_head].misaligned;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench running LATENCY=1 and LATENCY=2 instances side by side
module tb_branch_resolve_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_tag;
  logic [1:0]  in_kind;
  logic [2:0]  in_func;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_target;
  logic        in_pred_taken;
  logic        out_ready;

  logic        in_ready1, out_valid1, out_taken1, out_mis1, out_mal1;
  logic [4:0]  out_tag1;
  logic [31:0] out_link1, out_next1;
  logic        in_ready2, out_valid2, out_taken2, out_mis2, out_mal2;
  logic [4:0]  out_tag2;
  logic [31:0] out_link2, out_next2;

  always #5 clock = ~clock;

  branch_resolve_unit #(.XLEN(32), .TAG_W(5), .LATENCY(1), .OUT_DEPTH(4)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_tag(in_tag), .in_kind(in_kind),
    .in_func(in_func), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid1), .out_ready(out_ready), .out_tag(out_tag1), .out_taken(out_taken1),
    .out_link(out_link1), .out_next_pc(out_next1), .out_mispredict(out_mis1),
    .out_misaligned(out_mal1)
  );

  branch_resolve_unit #(.XLEN(32), .TAG_W(5), .LATENCY(2), .OUT_DEPTH(4)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_tag(in_tag), .in_kind(in_kind),
    .in_func(in_func), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid2), .out_ready(out_ready), .out_tag(out_tag2), .out_taken(out_taken2),
    .out_link(out_link2), .out_next_pc(out_next2), .out_mispredict(out_mis2),
    .out_misaligned(out_mal2)
  );

  typedef struct {
    logic [4:0]  tag;
    logic        taken;
    logic [31:0] link;
    logic [31:0] next_pc;
    logic        mis;
    logic        mal;
    logic        chk_link;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t exp_cur;
  int   total = 0;
  int   bad = 0;
  int   acc1 = 0;
  int   acc2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_out(input string who, input exp_t e, input logic [4:0] tag,
                           input logic taken, input logic [31:0] link,
                           input logic [31:0] nxt, input logic mis, input logic mal);
    chk({who, " tag"}, 32'(tag), 32'(e.tag));
    chk({who, " taken"}, 32'(taken), 32'(e.taken));
    chk({who, " next_pc"}, nxt, e.next_pc);
    chk({who, " mispredict"}, 32'(mis), 32'(e.mis));
    chk({who, " misaligned"}, 32'(mal), 32'(e.mal));
    if (e.chk_link) chk({who, " link"}, link, e.link);
  endtask

  // Monitor: inputs change at posedge+1, so everything is stable here.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n || flush) begin
      q1.delete();
      q2.delete();
    end else begin
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL dut1 unexpected output actual_tag=%0d required=none", out_tag1);
        end else begin
          e = q1.pop_front();
          check_out("dut1", e, out_tag1, out_taken1, out_link1, out_next1, out_mis1, out_mal1);
        end
      end
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) begin
          total++; bad++;
          $display("FAIL dut2 unexpected output actual_tag=%0d required=none", out_tag2);
        end else begin
          e = q2.pop_front();
          check_out("dut2", e, out_tag2, out_taken2, out_link2, out_next2, out_mis2, out_mal2);
        end
      end
      if (in_valid && in_ready1) begin q1.push_back(exp_cur); acc1++; end
      if (in_valid && in_ready2) begin q2.push_back(exp_cur); acc2++; end
    end
  end

  task automatic set_op(input logic [4:0] tag, input logic [1:0] kind, input logic [2:0] func,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic pt, input logic [31:0] ptgt,
                        input logic e_taken, input logic [31:0] e_next,
                        input logic e_mis, input logic e_mal);
    in_tag = tag; in_kind = kind; in_func = func; in_pc = pc; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_pred_taken = pt; in_pred_target = ptgt;
    exp_cur.tag = tag; exp_cur.taken = e_taken; exp_cur.link = pc + 32'd4;
    exp_cur.next_pc = e_next; exp_cur.mis = e_mis; exp_cur.mal = e_mal;
    exp_cur.chk_link = (kind == 2'd1) || (kind == 2'd2);
  endtask

  // Single-cycle issue pulse, raised only once both units have a credit.
  task automatic issue(input logic [4:0] tag, input logic [1:0] kind, input logic [2:0] func,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pt, input logic [31:0] ptgt,
                       input logic e_taken, input logic [31:0] e_next,
                       input logic e_mis, input logic e_mal);
    int n = 0;
    while (!(in_ready1 && in_ready2) && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) chk("issue wait for in_ready", 32'(n), 32'd0);
    set_op(tag, kind, func, pc, imm, rs1, rs2, pt, ptgt, e_taken, e_next, e_mis, e_mal);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || out_valid1 || out_valid2) && n < 100) begin
      @(posedge clock); #1; n++;
    end
    chk("drain within bound", 32'(n < 100), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd4, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset out_valid1", 32'(out_valid1), 32'd0);
    chk("reset out_valid2", 32'(out_valid2), 32'd0);
    chk("reset out_next_pc1", out_next1, 32'd0);
    chk("reset out_tag2", 32'(out_tag2), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("post-reset in_ready1", 32'(in_ready1), 32'd1);
    chk("post-reset in_ready2", 32'(in_ready2), 32'd1);

    // Directed vectors
    out_ready = 1'b1;
    issue(5'd1, 2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 1'b1, 32'h120, 1'b0, 1'b0);
    chk("lat1 out_valid one cycle after issue", 32'(out_valid1), 32'd1);
    chk("lat2 out_valid not yet", 32'(out_valid2), 32'd0);
    issue(5'd2, 2'd0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 32'h240, 1'b1, 1'b0);
    issue(5'd3, 2'd0, 3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b0, 32'h204, 1'b0, 1'b0);
    issue(5'd4, 2'd2, 3'b000, 32'h300, 32'h4, 32'h1001, 32'd0, 1'b1, 32'h1004, 1'b1, 32'h1004, 1'b0, 1'b0);
    issue(5'd5, 2'd2, 3'b000, 32'h300, 32'h0, 32'h1002, 32'd0, 1'b1, 32'h1002, 1'b1, 32'h1002, 1'b0, 1'b1);
    issue(5'd6, 2'd0, 3'b001, 32'h500, 32'h10, 32'd3, 32'd3, 1'b1, 32'h510, 1'b0, 32'h504, 1'b1, 1'b0);
    issue(5'd7, 2'd0, 3'b101, 32'h600, 32'h10, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h604, 1'b0, 1'b0);
    issue(5'd8, 2'd0, 3'b111, 32'h600, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h5F0, 1'b1, 32'h5F0, 1'b0, 1'b0);
    issue(5'd9, 2'd1, 3'b000, 32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0, 1'b1, 32'h8, 1'b1, 32'h4, 1'b1, 1'b0);
    issue(5'd12, 2'd3, 3'b000, 32'h700, 32'h40, 32'd1, 32'd1, 1'b1, 32'h740, 1'b0, 32'h704, 1'b1, 1'b0);
    issue(5'd13, 2'd0, 3'b010, 32'h800, 32'h40, 32'd1, 32'd1, 1'b0, 32'h0, 1'b0, 32'h804, 1'b0, 1'b0);
    drain();

    // Backpressure: six consecutive issue cycles, only four credits.
    out_ready = 1'b0;
    acc1 = 0; acc2 = 0;
    for (int i = 0; i < 6; i++) begin
      set_op(5'(i), 2'd1, 3'd0, 32'h400 + 32'(i * 4), 32'h8, 32'd0, 32'd0, 1'b1,
             32'h408 + 32'(i * 4), 1'b1, 32'h408 + 32'(i * 4), 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    chk("backpressure accepted dut1", 32'(acc1), 32'd4);
    chk("backpressure accepted dut2", 32'(acc2), 32'd4);
    chk("full in_ready1", 32'(in_ready1), 32'd0);
    chk("full in_ready2", 32'(in_ready2), 32'd0);
    out_ready = 1'b1;
    @(negedge clock);
    chk("in_ready1 during first dequeue", 32'(in_ready1), 32'd0);
    @(posedge clock); #1;
    chk("in_ready1 after first dequeue", 32'(in_ready1), 32'd1);
    chk("in_ready2 after first dequeue", 32'(in_ready2), 32'd1);
    drain();

    // Flush one cycle after two back-to-back issues.
    out_ready = 1'b0;
    issue(5'd10, 2'd1, 3'd0, 32'h900, 32'h8, 32'd0, 32'd0, 1'b1, 32'h908, 1'b1, 32'h908, 1'b0, 1'b0);
    issue(5'd11, 2'd1, 3'd0, 32'h904, 32'h8, 32'd0, 32'd0, 1'b1, 32'h90C, 1'b1, 32'h90C, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush in_ready1", 32'(in_ready1), 32'd0);
    chk("flush in_ready2", 32'(in_ready2), 32'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    #1;
    chk("after flush out_valid1", 32'(out_valid1), 32'd0);
    chk("after flush out_valid2", 32'(out_valid2), 32'd0);
    chk("after flush in_ready1", 32'(in_ready1), 32'd1);
    chk("after flush in_ready2", 32'(in_ready2), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    chk("no late result dut2", 32'(out_valid2), 32'd0);
    out_ready = 1'b1;
    issue(5'd14, 2'd0, 3'b000, 32'hA00, 32'h10, 32'd7, 32'd7, 1'b0, 32'h0, 1'b1, 32'hA10, 1'b1, 1'b0);
    drain();

    // Asynchronous reset with three buffered entries.
    out_ready = 1'b0;
    issue(5'd20, 2'd1, 3'd0, 32'hB00, 32'h8, 32'd0, 32'd0, 1'b1, 32'hB08, 1'b1, 32'hB08, 1'b0, 1'b0);
    issue(5'd21, 2'd1, 3'd0, 32'hB04, 32'h8, 32'd0, 32'd0, 1'b1, 32'hB0C, 1'b1, 32'hB0C, 1'b0, 1'b0);
    issue(5'd22, 2'd1, 3'd0, 32'hB08, 32'h8, 32'd0, 32'd0, 1'b1, 32'hB10, 1'b1, 32'hB10, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk("three buffered out_valid2", 32'(out_valid2), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset out_valid1", 32'(out_valid1), 32'd0);
    chk("async reset out_valid2", 32'(out_valid2), 32'd0);
    chk("async reset out_next_pc2", out_next2, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    chk("release in_ready1", 32'(in_ready1), 32'd1);
    chk("release in_ready2", 32'(in_ready2), 32'd1);
    out_ready = 1'b1;
    issue(5'd23, 2'd2, 3'd0, 32'hC00, 32'h10, 32'h2000, 32'd0, 1'b0, 32'h0, 1'b1, 32'h2010, 1'b1, 1'b0);
    drain();
    repeat (3) @(posedge clock);
    #1;
    chk("final out_valid1", 32'(out_valid1), 32'd0);
    chk("final queue1 empty", 32'(q1.size()), 32'd0);
    chk("final queue2 empty", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
